// File: rtl/sram_arbiter_pkg.sv
// Shared encodings for the BaseRAM arbiter: FSM states, grant ids and the
// strobe bundle that each state drives onto the SRAM pins.
package sram_arbiter_pkg;

    localparam logic [2:0] SA_IDLE     = 3'd0;
    localparam logic [2:0] SA_RD       = 3'd1;
    localparam logic [2:0] SA_WR_SETUP = 3'd2;
    localparam logic [2:0] SA_WR_PULSE = 3'd3;
    localparam logic [2:0] SA_WR_HOLD  = 3'd4;
    localparam logic [2:0] SA_DONE     = 3'd5;

    localparam logic GRANT_IF  = 1'b0;
    localparam logic GRANT_MEM = 1'b1;

    localparam int WAIT_CYCLES_DEF = 1;

    typedef struct packed {
        logic ce_n;
        logic oe_n;
        logic we_n;
        logic data_oe;
    } strobe_t;

    localparam strobe_t STROBE_IDLE = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, data_oe: 1'b0};

    // Pin levels for a state; registered from the next state so pins change
    // on the same edge the FSM enters the state.
    function automatic strobe_t strobes_for(input logic [2:0] st);
        strobe_t s;
        s = STROBE_IDLE;
        case (st)
            SA_RD: begin
                s.ce_n = 1'b0;
                s.oe_n = 1'b0;
            end
            SA_WR_SETUP, SA_WR_HOLD: begin
                s.ce_n    = 1'b0;
                s.data_oe = 1'b1;
            end
            SA_WR_PULSE: begin
                s.ce_n    = 1'b0;
                s.we_n    = 1'b0;
                s.data_oe = 1'b1;
            end
            default: s = STROBE_IDLE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/sram_arbiter_rr_pick.sv
// Two-way round-robin pick: req[0] is instruction fetch, req[1] is data memory.
// On a tie the port opposite to the last grant wins.
module sram_rr_pick
    import sram_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant,
    output logic       valid
);

    always_comb begin
        valid = |req;
        grant = GRANT_IF;
        if (req == 2'b11) begin
            grant = ~last;
        end else if (req[1]) begin
            grant = GRANT_MEM;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one asynchronous 32-bit SRAM between the fetch and data ports with a
// registered req/ack handshake and programmable wait states.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// IDLE        | strobes off, arbitrate pending requests
// RD          | ce_n/oe_n low for WAIT_CYCLES+1 cycles, capture on last edge
// WR_SETUP    | address/data driven, we_n still high
// WR_PULSE    | we_n low for WAIT_CYCLES cycles
// WR_HOLD     | we_n high, data still driven
// DONE        | ack to granted port, bus turnaround, back to IDLE
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,

    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_sel,
    output logic [31:0] mem_rdata,
    output logic        mem_ack,

    output logic        stall_o,

    input  logic [31:0] sram_data_i,
    output logic [31:0] sram_data_o,
    output logic        sram_data_oe,
    output logic [19:0] sram_addr,
    output logic [3:0]  sram_be_n,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n
);

    localparam logic [3:0] RD_LOAD    = 4'(WAIT_CYCLES);
    localparam logic [3:0] PULSE_LOAD = 4'(WAIT_CYCLES - 1);

    logic [2:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        last_q, last_d;
    logic        gnt_q, gnt_d;
    logic [19:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_n_q, be_n_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic        if_ack_q, if_ack_d;
    logic        mem_ack_q, mem_ack_d;
    strobe_t     strobe_q, strobe_d;

    logic pick_grant;
    logic pick_valid;

    sram_rr_pick u_pick (
        .req   ({mem_req, if_req}),
        .last  (last_q),
        .grant (pick_grant),
        .valid (pick_valid)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        gnt_d       = gnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_n_d      = be_n_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;

        case (state_q)
            SA_IDLE: begin
                if (pick_valid) begin
                    gnt_d  = pick_grant;
                    last_d = pick_grant;
                    cnt_d  = RD_LOAD;
                    if (pick_grant == GRANT_MEM) begin
                        addr_d = mem_addr[21:2];
                        if (mem_we) begin
                            wdata_d = mem_wdata;
                            be_n_d  = ~mem_sel;
                            state_d = SA_WR_SETUP;
                        end else begin
                            be_n_d  = 4'b0000;
                            state_d = SA_RD;
                        end
                    end else begin
                        addr_d  = if_addr[21:2];
                        be_n_d  = 4'b0000;
                        state_d = SA_RD;
                    end
                end
            end
            SA_RD: begin
                if (cnt_q == 4'd0) begin
                    if (gnt_q == GRANT_MEM) begin
                        mem_rdata_d = sram_data_i;
                    end else begin
                        if_rdata_d = sram_data_i;
                    end
                    state_d = SA_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            SA_WR_SETUP: begin
                cnt_d   = PULSE_LOAD;
                state_d = SA_WR_PULSE;
            end
            SA_WR_PULSE: begin
                if (cnt_q == 4'd0) begin
                    state_d = SA_WR_HOLD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            SA_WR_HOLD: state_d = SA_DONE;
            SA_DONE:    state_d = SA_IDLE;
            default:    state_d = SA_IDLE;
        endcase
    end

    // Ack and strobes come from the next state so every pin is a flop output.
    always_comb begin
        strobe_d  = strobes_for(state_d);
        if_ack_d  = (state_d == SA_DONE) && (gnt_d == GRANT_IF);
        mem_ack_d = (state_d == SA_DONE) && (gnt_d == GRANT_MEM);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= SA_IDLE;
            cnt_q       <= 4'd0;
            last_q      <= GRANT_IF;
            gnt_q       <= GRANT_IF;
            addr_q      <= 20'd0;
            wdata_q     <= 32'd0;
            be_n_q      <= 4'b1111;
            if_rdata_q  <= 32'd0;
            mem_rdata_q <= 32'd0;
            if_ack_q    <= 1'b0;
            mem_ack_q   <= 1'b0;
            strobe_q    <= STROBE_IDLE;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            gnt_q       <= gnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_n_q      <= be_n_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            if_ack_q    <= if_ack_d;
            mem_ack_q   <= mem_ack_d;
            strobe_q    <= strobe_d;
        end
    end

    assign if_rdata     = if_rdata_q;
    assign if_ack       = if_ack_q;
    assign mem_rdata    = mem_rdata_q;
    assign mem_ack      = mem_ack_q;
    assign sram_data_o  = wdata_q;
    assign sram_data_oe = strobe_q.data_oe;
    assign sram_addr    = addr_q;
    assign sram_be_n    = be_n_q;
    assign sram_ce_n    = strobe_q.ce_n;
    assign sram_oe_n    = strobe_q.oe_n;
    assign sram_we_n    = strobe_q.we_n;

    assign stall_o = (if_req & ~if_ack_q) | (mem_req & ~mem_ack_q);

    // Only the BaseRAM word-address bits reach the pins.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[31:22], if_addr[1:0], mem_addr[31:22], mem_addr[1:0]};

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: SRAM behavioural model, per-port scoreboards
// popped on ack, and a second instance with three wait states.
module tb_sram_arbiter;

    logic        clk;
    logic        rst;

    logic        if_req, mem_req, mem_we;
    logic [31:0] if_addr, mem_addr, mem_wdata;
    logic [3:0]  mem_sel;
    logic [31:0] if_rdata, mem_rdata;
    logic        if_ack, mem_ack, stall_o;
    logic [31:0] sram_data_i, sram_data_o;
    logic        sram_data_oe;
    logic [19:0] sram_addr;
    logic [3:0]  sram_be_n;
    logic        sram_ce_n, sram_oe_n, sram_we_n;

    logic        if_req3;
    logic [31:0] if_addr3;
    logic [31:0] if_rdata3, mem_rdata3;
    logic        if_ack3, mem_ack3, stall3;
    logic [31:0] sram_data_i3, sram_data_o3;
    logic        sram_data_oe3;
    logic [19:0] sram_addr3;
    logic [3:0]  sram_be_n3;
    logic        sram_ce_n3, sram_oe_n3, sram_we_n3;

    logic [31:0] sram_mem [0:1023];

    typedef struct {
        bit          chk;
        logic [31:0] data;
    } sb_t;

    sb_t if_q[$];
    sb_t mem_q[$];
    bit  ack_log[$];

    int n_checks = 0;
    int n_pass   = 0;
    int turn_viol = 0;
    int dbl_ack   = 0;
    int mem_ack_cnt = 0;
    logic prev_doe = 1'b0;
    logic prev_if_ack = 1'b0;
    logic prev_mem_ack = 1'b0;

    logic        log_oe  [0:31];
    logic        log_we  [0:31];
    logic        log_doe [0:31];
    logic [19:0] log_addr[0:31];
    logic [3:0]  log_be  [0:31];

    sram_arbiter #(.WAIT_CYCLES(1)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_sel(mem_sel), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall_o(stall_o),
        .sram_data_i(sram_data_i), .sram_data_o(sram_data_o), .sram_data_oe(sram_data_oe),
        .sram_addr(sram_addr), .sram_be_n(sram_be_n), .sram_ce_n(sram_ce_n),
        .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
    );

    sram_arbiter #(.WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .rst(rst),
        .if_req(if_req3), .if_addr(if_addr3), .if_rdata(if_rdata3), .if_ack(if_ack3),
        .mem_req(1'b0), .mem_we(1'b0), .mem_addr(32'd0), .mem_wdata(32'd0),
        .mem_sel(4'd0), .mem_rdata(mem_rdata3), .mem_ack(mem_ack3),
        .stall_o(stall3),
        .sram_data_i(sram_data_i3), .sram_data_o(sram_data_o3), .sram_data_oe(sram_data_oe3),
        .sram_addr(sram_addr3), .sram_be_n(sram_be_n3), .sram_ce_n(sram_ce_n3),
        .sram_oe_n(sram_oe_n3), .sram_we_n(sram_we_n3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign sram_data_i  = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr[9:0]] : 32'h0;
    assign sram_data_i3 = (!sram_ce_n3 && !sram_oe_n3) ? sram_mem[sram_addr3[9:0]] : 32'h0;

    // Write model: bytes land at the end of every cycle with we_n low.
    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n) begin
            for (int b = 0; b < 4; b++) begin
                if (!sram_be_n[b]) sram_mem[sram_addr[9:0]][8*b +: 8] <= sram_data_o[8*b +: 8];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    always @(negedge clk) begin
        sb_t e;
        if (!sram_oe_n && prev_doe) turn_viol++;
        if (if_ack && prev_if_ack) dbl_ack++;
        if (mem_ack && prev_mem_ack) dbl_ack++;
        prev_doe     = sram_data_oe;
        prev_if_ack  = if_ack;
        prev_mem_ack = mem_ack;
        if (if_ack) begin
            ack_log.push_back(1'b0);
            check("if_sb_nonempty", 32'(if_q.size() > 0), 32'd1);
            if (if_q.size() > 0) begin
                e = if_q.pop_front();
                if (e.chk) check("if_rdata", if_rdata, e.data);
            end
        end
        if (mem_ack) begin
            mem_ack_cnt++;
            ack_log.push_back(1'b1);
            check("mem_sb_nonempty", 32'(mem_q.size() > 0), 32'd1);
            if (mem_q.size() > 0) begin
                e = mem_q.pop_front();
                if (e.chk) check("mem_rdata", mem_rdata, e.data);
            end
        end
    end

    task automatic do_access(input bit is_mem, input bit we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] sel,
                             input logic [31:0] exp, output int ack_cyc);
        @(posedge clk); #1;
        if (is_mem) begin
            mem_q.push_back('{chk: !we, data: exp});
            mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_wdata = wdata; mem_sel = sel;
        end else begin
            if_q.push_back('{chk: 1'b1, data: exp});
            if_req = 1'b1; if_addr = addr;
        end
        ack_cyc = -1;
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            log_oe[c] = sram_oe_n; log_we[c] = sram_we_n; log_doe[c] = sram_data_oe;
            log_addr[c] = sram_addr; log_be[c] = sram_be_n;
            if (is_mem ? mem_ack : if_ack) begin
                ack_cyc = c;
                break;
            end
        end
        @(posedge clk); #1;
        if_req = 1'b0; mem_req = 1'b0;
    endtask

    initial begin
        int ack_cyc;
        int stall_lo;
        int oe_cnt;
        logic [31:0] rd3;
        logic [4:0] mask;

        for (int i = 0; i < 1024; i++) sram_mem[i] = 32'h0;
        sram_mem[4]    = 32'hDEAD_BEEF;
        sram_mem[10'h40] = 32'h1122_3344;
        rst = 1'b0;
        if_req = 1'b0; if_addr = 32'h0;
        mem_req = 1'b0; mem_we = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0; mem_sel = 4'h0;
        if_req3 = 1'b0; if_addr3 = 32'h0;

        repeat (3) @(negedge clk);
        check("rst_ce_n", 32'(sram_ce_n), 32'd1);
        check("rst_oe_n", 32'(sram_oe_n), 32'd1);
        check("rst_we_n", 32'(sram_we_n), 32'd1);
        check("rst_be_n", 32'(sram_be_n), 32'hF);
        check("rst_data_oe", 32'(sram_data_oe), 32'd0);
        check("rst_addr", 32'(sram_addr), 32'd0);
        check("rst_data_o", sram_data_o, 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_mem_rdata", mem_rdata, 32'd0);
        check("rst_acks", 32'({if_ack, mem_ack}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Both ports held: first tie after reset goes to MEM, then alternates.
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            if_q.push_back('{chk: 1'b1, data: 32'hDEAD_BEEF});
            mem_q.push_back('{chk: 1'b0, data: 32'h0});
        end
        ack_log.delete();
        if_req = 1'b1; if_addr = 32'h8000_0010;
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h8000_0300; mem_wdata = 32'h0BAD_F00D; mem_sel = 4'hF;
        stall_lo = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk); #1;
            if (!stall_o) stall_lo++;
            if (ack_log.size() >= 4) break;
        end
        @(posedge clk); #1;
        if_req = 1'b0; mem_req = 1'b0;
        @(negedge clk);
        check("tie_ack_count", 32'(ack_log.size()), 32'd4);
        if (ack_log.size() >= 4) begin
            check("tie_grant0", 32'(ack_log[0]), 32'd1);
            check("tie_grant1", 32'(ack_log[1]), 32'd0);
            check("tie_grant2", 32'(ack_log[2]), 32'd1);
            check("tie_grant3", 32'(ack_log[3]), 32'd0);
        end
        check("tie_stall_held", 32'(stall_lo), 32'd0);
        check("tie_stall_dropped", 32'(stall_o), 32'd0);
        check("tie_write_word", sram_mem[10'hC0], 32'h0BAD_F00D);

        // IF read, one wait state.
        do_access(1'b0, 1'b0, 32'h8000_0010, 32'h0, 4'h0, 32'hDEAD_BEEF, ack_cyc);
        check("ifrd_ack_cycle", 32'(ack_cyc), 32'd3);
        check("ifrd_addr_c1", 32'(log_addr[1]), 32'h00004);
        check("ifrd_oe_c0", 32'(log_oe[0]), 32'd1);
        check("ifrd_oe_c1", 32'(log_oe[1]), 32'd0);
        check("ifrd_oe_c2", 32'(log_oe[2]), 32'd0);
        check("ifrd_oe_c3", 32'(log_oe[3]), 32'd1);

        // MEM byte write to lane 1.
        do_access(1'b1, 1'b1, 32'h8000_0100, 32'h1234_5678, 4'b0010, 32'h0, ack_cyc);
        check("memwr_ack_cycle", 32'(ack_cyc), 32'd4);
        check("memwr_be_n", 32'(log_be[1]), 32'b1101);
        for (int c = 0; c < 5; c++) mask[c] = !log_we[c];
        check("memwr_we_low_mask", 32'(mask), 32'b00100);
        for (int c = 0; c < 5; c++) mask[c] = log_doe[c];
        check("memwr_doe_mask", 32'(mask), 32'b01110);
        check("memwr_model_word", sram_mem[10'h40], 32'h1122_5644);

        // Write then read back the same word.
        do_access(1'b1, 1'b1, 32'h8000_0200, 32'hA5A5_5A5A, 4'hF, 32'h0, ack_cyc);
        check("wr_then_rd_wr_ack", 32'(ack_cyc), 32'd4);
        do_access(1'b1, 1'b0, 32'h8000_0200, 32'h0, 4'h0, 32'hA5A5_5A5A, ack_cyc);
        check("wr_then_rd_rd_ack", 32'(ack_cyc), 32'd3);

        // Reset in the middle of the write pulse.
        @(posedge clk); #1;
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h8000_0400; mem_wdata = 32'hFFFF_FFFF; mem_sel = 4'hF;
        ack_cyc = -1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (!sram_we_n) begin
                ack_cyc = c;
                break;
            end
        end
        check("rstwr_pulse_seen", 32'(ack_cyc), 32'd2);
        oe_cnt = mem_ack_cnt;
        rst = 1'b0;
        #1;
        check("rstwr_we_n", 32'(sram_we_n), 32'd1);
        check("rstwr_data_oe", 32'(sram_data_oe), 32'd0);
        check("rstwr_ce_n", 32'(sram_ce_n), 32'd1);
        @(posedge clk); #1;
        mem_req = 1'b0;
        mem_q.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (8) @(negedge clk);
        check("rstwr_no_ack", 32'(mem_ack_cnt), 32'(oe_cnt));
        do_access(1'b0, 1'b0, 32'h8000_0010, 32'h0, 4'h0, 32'hDEAD_BEEF, ack_cyc);
        check("rstwr_if_ack_cycle", 32'(ack_cyc), 32'd3);

        // Three wait states on the second instance.
        @(posedge clk); #1;
        if_req3 = 1'b1; if_addr3 = 32'h8000_0010;
        ack_cyc = -1; oe_cnt = 0; rd3 = 32'h0;
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            if (!sram_oe_n3) oe_cnt++;
            if (if_ack3) begin
                ack_cyc = c;
                rd3 = if_rdata3;
                break;
            end
        end
        @(posedge clk); #1;
        if_req3 = 1'b0;
        check("w3_ack_cycle", 32'(ack_cyc), 32'd5);
        check("w3_oe_low_cycles", 32'(oe_cnt), 32'd4);
        check("w3_rdata", rd3, 32'hDEAD_BEEF);

        repeat (3) @(negedge clk);
        check("turnaround_gap", 32'(turn_viol), 32'd0);
        check("ack_single_pulse", 32'(dbl_ack), 32'd0);
        check("if_sb_drained", 32'(if_q.size()), 32'd0);
        check("mem_sb_drained", 32'(mem_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
